// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the fetch front end
package fetch_pkg;

  localparam int          FETCH_AW         = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [31:0]         inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries; flush beats push/pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int        PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [PW:0]  wptr;
  logic [PW:0]  rptr;
  fetch_entry_t mem [DEPTH];
  logic         empty;
  logic         full;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[PW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, imem issue and decoupling FIFO ahead of decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_address,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_target,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              dec_inst,
  output logic [AW-1:0]            dec_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          squash;
  logic [CW:0]   pending;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  // Pop is ignored in the budget so a full FIFO can never be overrun.
  assign pending  = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  assign issue    = !reset && !redirect_valid && (pending < (CW+1)'(DEPTH));
  assign imem_req = issue;
  assign imem_address = reset ? RESET_PC : pc;

  assign push           = inflight && !squash && !redirect_valid && !reset;
  assign pop            = dec_valid && dec_ready && !redirect_valid;
  assign push_data.pc   = FETCH_AW'(inflight_pc);
  assign push_data.inst = imem_data;

  assign dec_valid = !reset && (occupancy != '0);
  assign dec_inst  = dec_valid ? head.inst : (reset ? 32'h0 : INST_NOP);
  assign dec_pc    = dec_valid ? AW'(head.pc) : '0;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (occupancy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc       <= redirect_target & ~AW'(3);
        inflight <= 1'b0;
      end else if (issue) begin
        pc          <= pc + AW'(4);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
      // A return retires any pending squash; single-cycle memory never arms it.
      if (inflight) squash <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue
module tb_fetch_queue;

  localparam logic [31:0] A0 = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_pc;

  fetch_queue #(.DEPTH(4), .AW(32), .RESET_PC(32'h0100_0000)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_address    (imem_address),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_ready       (dec_ready),
    .dec_valid       (dec_valid),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .occupancy       (occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Single-cycle memory: the word for this cycle's address arrives next cycle.
  always @(posedge clock) imem_data <= inst_of(imem_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_head(input string name);
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_inst !== inst_of(exp_pc)) begin
      failures++;
      $display("FAIL %s: valid=%b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
               name, dec_valid, dec_pc, dec_inst, exp_pc, inst_of(exp_pc));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (3) tick();
    #1;
    checks++;
    if (dec_valid !== 1'b0 || occupancy !== 3'd0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: valid=%b occ=%0d req=%b expected 0 0 0", dec_valid, occupancy, imem_req);
    end
    checks++;
    if (imem_address !== A0 || dec_pc !== 32'h0 || dec_inst !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%h pc=%h inst=%h expected %h 0 0", imem_address, dec_pc, dec_inst, A0);
    end
  endtask

  task automatic test_stream();
    exp_pc = A0;
    for (int k = 0; k < 8; k++) begin
      tick();
      reset = 1'b0; dec_ready = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_address !== A0 + 32'(4 * k)) begin
        failures++;
        $display("FAIL stream_issue%0d: req=%b addr=%h expected 1 %h", k, imem_req, imem_address, A0 + 32'(4 * k));
      end
      if (k >= 2) begin
        expect_head("stream_head");
        exp_pc += 4;
      end else begin
        checks++;
        if (dec_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_latency%0d: valid=%b expected 0", k, dec_valid);
        end
      end
    end
    checks++;
    if (occupancy !== 3'd1) begin
      failures++;
      $display("FAIL stream_occ: occ=%0d expected 1", occupancy);
    end
  endtask

  task automatic test_backpressure();
    for (int s = 0; s < 10; s++) begin
      tick();
      dec_ready = 1'b0;
      #1;
      expect_head("stall_head");
      checks++;
      if (imem_req !== (s < 2)) begin
        failures++;
        $display("FAIL stall_req%0d: req=%b expected %b", s, imem_req, (s < 2));
      end
      if (s >= 3) begin
        checks++;
        if (occupancy !== 3'd4) begin
          failures++;
          $display("FAIL stall_occ%0d: occ=%0d expected 4", s, occupancy);
        end
      end
    end
    for (int r = 0; r < 8; r++) begin
      tick();
      dec_ready = 1'b1;
      #1;
      expect_head("release_head");
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect();
    tick();
    dec_ready = 1'b0;
    #1;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0100_0100;
    #1;
    checks++;
    if (occupancy !== 3'd3 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_cycle: occ=%0d req=%b expected 3 0", occupancy, imem_req);
    end
    tick();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_address !== 32'h0100_0100) begin
      failures++;
      $display("FAIL redir_flush: occ=%0d valid=%b req=%b addr=%h expected 0 0 1 01000100",
               occupancy, dec_valid, imem_req, imem_address);
    end
    tick();
    #1;
    checks++;
    if (dec_valid !== 1'b0 || imem_address !== 32'h0100_0104) begin
      failures++;
      $display("FAIL redir_gap: valid=%b addr=%h expected 0 01000104", dec_valid, imem_address);
    end
    exp_pc = 32'h0100_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      expect_head("redir_head");
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect_misaligned();
    tick();
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0100_0102;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_req: req=%b expected 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    #1;
    checks++;
    if (imem_address !== 32'h0100_0100 || occupancy !== 3'd0) begin
      failures++;
      $display("FAIL misalign_addr: addr=%h occ=%0d expected 01000100 0", imem_address, occupancy);
    end
    tick();
    exp_pc = 32'h0100_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      expect_head("misalign_head");
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect_pop_collision();
    tick();
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0100_0200;
    #1;
    expect_head("collide_pre");
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_address !== 32'h0100_0200) begin
      failures++;
      $display("FAIL collide_flush: occ=%0d valid=%b addr=%h expected 0 0 01000200",
               occupancy, dec_valid, imem_address);
    end
    tick();
    #1;
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_stale: valid=%b pc=%h expected valid 0", dec_valid, dec_pc);
    end
    exp_pc = 32'h0100_0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      expect_head("collide_head");
      exp_pc += 4;
    end
  endtask

  task automatic test_reset_priority();
    tick();
    dec_ready = 1'b0;
    #1;
    tick();
    tick();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0100_0300;
    #1;
    checks++;
    if (occupancy !== 3'd3 || imem_req !== 1'b0 || dec_valid !== 1'b0 || imem_address !== A0) begin
      failures++;
      $display("FAIL rstpri_cycle: occ=%0d req=%b valid=%b addr=%h expected 3 0 0 %h",
               occupancy, imem_req, dec_valid, imem_address, A0);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstpri_clear: occ=%0d valid=%b req=%b expected 0 0 0", occupancy, dec_valid, imem_req);
    end
    tick();
    reset = 1'b0; dec_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_address !== A0) begin
      failures++;
      $display("FAIL rstpri_issue: req=%b addr=%h expected 1 %h", imem_req, imem_address, A0);
    end
    tick();
    exp_pc = A0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      expect_head("rstpri_head");
      exp_pc += 4;
    end
  endtask

  initial begin
    reset = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_misaligned();
    test_redirect_pop_collision();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
